dt_seq_engine: RTL and testbench
================================

Name: dt_seq_engine

Overview:
- Programmable, sequential decision-tree classifier; the parametrised successor of the fixed-threshold combinational fault-classification trees.
- Node table (feature select, threshold, leaf flag/class) is register-based and written through a config port at run time, so one netlist serves any trained tree up to DEPTH levels.
- Evaluates one tree level per clock and returns class, levels traversed and error flag over valid/ready handshakes.
- Sits between the quantised sample front-end (Va,Vb,Vc,Ia,Ib,Ic) and the fault-report logic.

Parameters:
- N, 8, feature and threshold width (unsigned).
- F, 6, number of features; feature k occupies feat_in[k*N +: N].
- C, 3, class width; C <= N.
- DEPTH, 5, maximum number of internal levels; NODES = 2^(DEPTH+1)-1 table entries.
- FIW, $clog2(F), feature-index width (derived).
- AW, DEPTH+1, node-address width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  AW  node index (0 = root; children of i are 2i+1 (less) and 2i+2 (not less)).
- cfg_data  in  1+FIW+N  {is_leaf, feat_idx, thr}; for a leaf, class = thr[C-1:0].
- cfg_busy  out  1  high when the state is not IDLE; writes are ignored while high.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine can accept a vector.
- feat_in  in  F*N  packed features.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- cls  out  C  class.
- out_depth  out  AW  internal nodes traversed.
- out_err  out  1  an out-of-range feat_idx was used on the path.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; cls=0; out_depth=0; out_err=0; cfg_busy=0. Every table entry resets to {1,0,0} (leaf, class 0). Reset mid-evaluation aborts it and the result is discarded; the table content is lost.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = !cfg_we. A write has priority over input acceptance in the same cycle.
  - A write stores cfg_data at cfg_addr on the edge. Addresses >= NODES are ignored.
  - On in_valid&&in_ready, feat_in is registered, node=0, depth=0, err=0, and the state moves to RUN.
- RUN (one node per cycle):
  - Read entry[node]. The node is a leaf if is_leaf=1 or node is on level DEPTH (node >= 2^DEPTH-1).
  - Leaf: cls<=thr[C-1:0], out_depth<=depth, out_err<=err, out_valid<=1, state moves to DONE.
  - Internal: f = feat_idx<F ? feature[feat_idx] : 0, and err is set when feat_idx>=F. The compare is unsigned f<thr. Less goes to node 2i+1, otherwise 2i+2. depth increments.
- Latency: handshake on edge k means out_valid is high after edge k+1+d, where d = out_depth (max DEPTH).
- DONE:
  - out_valid, cls, out_depth and out_err hold stable while out_ready=0.
  - On out_ready, out_valid<=0 and the state returns to IDLE. in_ready is high from the next cycle, so a back-to-back input is not accepted in the same edge.
- Config writes during RUN or DONE are dropped with no side effect. cfg_busy signals this condition.
- The compare is strictly less-than: equality takes the "not less" child.

Test Plan:
- Reset, no writes, then feat_in with all features = 0x55 -> out_valid one cycle after the next edge following acceptance; cls=0, out_depth=0, out_err=0.
- Program root {0,F=4(Ib),thr=120}, node1 leaf cls=4, node2 leaf cls=3. Ib=119 -> cls=4, depth=1. Ib=120 -> cls=3 (equality goes right). Ib=255 -> cls=3.
- Program a full chain of internal nodes down to level DEPTH=5 with thr=255, then apply any input -> traverses nodes 0,1,3,7,15,31; level-5 node 31 is forced leaf; out_depth=5; latency 6 cycles after acceptance.
- Root feat_idx=7 (>=F), thr=1 -> feature treated as 0, goes left, out_err=1. A following run with a valid path gives out_err=0.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. A cfg_we in DONE leaves the table unchanged (read back via a later run). Assert cfg_we and in_valid together in IDLE -> write happens, input is not accepted that cycle.
- Assert rst while in RUN at depth 2 -> next cycle IDLE, out_valid=0, table back to leaf/class 0. A subsequent input gives cls=0, depth=0.

Source files
------------

// File: rtl/dt_seq_engine_if.sv
// Bus bundle for dt_seq_engine: config write port, feature input handshake
// and result output handshake. The engine sits on the slave modport.
interface dt_seq_engine_if #(
    parameter int N     = 8,
    parameter int F     = 6,
    parameter int C     = 3,
    parameter int DEPTH = 5
);
    localparam int FIW = (F > 1) ? $clog2(F) : 1;
    localparam int AW  = DEPTH + 1;

    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [FIW+N:0]       cfg_data;
    logic                 cfg_busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [F*N-1:0]       feat_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [C-1:0]         cls;
    logic [AW-1:0]        out_depth;
    logic                 out_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, feat_in, out_ready,
        input  cfg_busy, in_ready, out_valid, cls, out_depth, out_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, feat_in, out_ready,
        output cfg_busy, in_ready, out_valid, cls, out_depth, out_err
    );
endinterface

// File: rtl/dt_seq_engine.sv
// Sequential decision-tree classifier. A register-based node table holds a
// complete binary tree (root 0, children 2i+1 / 2i+2); one level is walked
// per clock and the reached leaf class is returned over valid/ready.
module dt_seq_engine #(
    parameter int N     = 8,
    parameter int F     = 6,
    parameter int C     = 3,
    parameter int DEPTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    dt_seq_engine_if.slave     bus
);
    localparam int FIW   = (F > 1) ? $clog2(F) : 1;
    localparam int AW    = DEPTH + 1;
    localparam int NODES = (1 << (DEPTH + 1)) - 1;

    // First node index on the bottom level; such nodes are always leaves.
    localparam logic [AW-1:0] LAST_LVL = AW'((1 << DEPTH) - 1);
    localparam logic [AW:0]   NODES_W  = (AW+1)'(NODES);

    typedef struct packed {
        logic           leaf;
        logic [FIW-1:0] fidx;
        logic [N-1:0]   thr;
    } node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    node_t            tbl_q [NODES];
    logic [F*N-1:0]   feat_q, feat_d;
    logic [AW-1:0]    node_q, node_d;
    logic [AW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;
    logic [C-1:0]     cls_q, cls_d;
    logic [AW-1:0]    odep_q, odep_d;
    logic             oerr_q, oerr_d;
    logic             ovld_q, ovld_d;

    node_t            cur;
    logic [N-1:0]     f_sel;
    logic             f_bad;
    logic             is_leaf;
    logic             less;
    logic [AW-1:0]    child;
    logic             tbl_we;

    // Table writes are accepted only while idle and for in-range addresses.
    assign tbl_we = (state_q == IDLE) && bus.cfg_we && ({1'b0, bus.cfg_addr} < NODES_W);

    // Current node decode: feature select, compare and child address.
    always_comb begin
        cur   = tbl_q[node_q];
        f_sel = '0;
        for (int k = 0; k < F; k++) begin
            if (cur.fidx == FIW'(k)) f_sel = feat_q[k*N +: N];
        end
        f_bad   = (int'(cur.fidx) >= F);
        is_leaf = cur.leaf || (node_q >= LAST_LVL);
        less    = (f_sel < cur.thr);
        child   = {node_q[AW-2:0], 1'b0} + (less ? AW'(1) : AW'(2));
    end

    // Next-state and datapath updates for IDLE / RUN / DONE.
    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        node_d  = node_q;
        depth_d = depth_q;
        err_d   = err_q;
        cls_d   = cls_q;
        odep_d  = odep_q;
        oerr_d  = oerr_q;
        ovld_d  = ovld_q;
        case (state_q)
            IDLE: begin
                // A config write in the same cycle blocks input acceptance.
                if (bus.in_valid && !bus.cfg_we) begin
                    feat_d  = bus.feat_in;
                    node_d  = '0;
                    depth_d = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (is_leaf) begin
                    cls_d   = cur.thr[C-1:0];
                    odep_d  = depth_q;
                    oerr_d  = err_q;
                    ovld_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    node_d  = child;
                    depth_d = depth_q + AW'(1);
                    err_d   = err_q | f_bad;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            feat_q  <= '0;
            node_q  <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            cls_q   <= '0;
            odep_q  <= '0;
            oerr_q  <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            node_q  <= node_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            cls_q   <= cls_d;
            odep_q  <= odep_d;
            oerr_q  <= oerr_d;
            ovld_q  <= ovld_d;
        end
    end

    // Node table; reset turns every entry into a class-0 leaf.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                tbl_q[i] <= '{leaf: 1'b1, fidx: '0, thr: '0};
            end
        end else if (tbl_we) begin
            tbl_q[bus.cfg_addr] <= node_t'(bus.cfg_data);
        end
    end

    assign bus.cfg_busy  = (state_q != IDLE);
    assign bus.in_ready  = (state_q == IDLE) && !bus.cfg_we;
    assign bus.out_valid = ovld_q;
    assign bus.cls       = cls_q;
    assign bus.out_depth = odep_q;
    assign bus.out_err   = oerr_q;

endmodule

// File: tb/tb_dt_seq_engine.sv
// Scoreboard bench for dt_seq_engine: the driver pushes the hand-computed
// result and arrival cycle of each vector; a monitor checks every result.
module tb_dt_seq_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dt_seq_engine_if #(.N(8), .F(6), .C(3), .DEPTH(5)) bus ();

    dt_seq_engine #(.N(8), .F(6), .C(3), .DEPTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] c;
        logic [5:0] d;
        logic       e;
        int         t;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] nd(input logic leaf, input logic [2:0] fi, input logic [7:0] thr);
        return {leaf, fi, thr};
    endfunction

    // feature 4 (Ib) and feature 0 set, others zero
    function automatic logic [47:0] fv(input logic [7:0] ib, input logic [7:0] f0);
        logic [47:0] v;
        v = '0;
        v[39:32] = ib;
        v[7:0]   = f0;
        return v;
    endfunction

    task automatic cfg_write(input logic [5:0] a, input logic [11:0] d);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic issue(input logic [47:0] f, input logic [2:0] c, input logic [5:0] d, input logic e);
        int g;
        exp_t x;
        @(negedge clk);
        bus.feat_in  = f;
        bus.in_valid = 1'b1;
        #1;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        x.c = c; x.d = d; x.e = e; x.t = cyc + 2 + int'(d);
        q.push_back(x);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int g;
        g = 0;
        while (!bus.out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (bus.out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("out_valid_stuck", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [47:0] f, input logic [2:0] c, input logic [5:0] d, input logic e);
        issue(f, c, d, e);
        wait_valid();
        wait_done();
    endtask

    // Monitor: compares on the first cycle of each result, then checks that
    // the result holds while it is still presented.
    initial begin
        exp_t cur;
        bit   act;
        act = 1'b0;
        cur = '{c: 3'd0, d: 6'd0, e: 1'b0, t: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
            end else if (bus.out_valid && !act) begin
                act = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    cur = q.pop_front();
                    chk("cls", 32'(bus.cls), 32'(cur.c));
                    chk("out_depth", 32'(bus.out_depth), 32'(cur.d));
                    chk("out_err", 32'(bus.out_err), 32'(cur.e));
                    chk("latency", 32'(cyc), 32'(cur.t));
                    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
                end
            end else if (bus.out_valid && act) begin
                chk("hold_cls", 32'(bus.cls), 32'(cur.c));
                chk("hold_depth", 32'(bus.out_depth), 32'(cur.d));
                chk("hold_err", 32'(bus.out_err), 32'(cur.e));
                chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end else begin
                act = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.feat_in   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_cls", 32'(bus.cls), 32'd0);
        chk("rst_depth", 32'(bus.out_depth), 32'd0);
        chk("rst_err", 32'(bus.out_err), 32'd0);
        chk("rst_busy", 32'(bus.cfg_busy), 32'd0);

        // empty table: root is a class-0 leaf
        run({6{8'h55}}, 3'd0, 6'd0, 1'b0);

        // root on Ib, thr 120; strict less-than
        cfg_write(6'd0, nd(1'b0, 3'd4, 8'd120));
        cfg_write(6'd1, nd(1'b1, 3'd0, 8'd4));
        cfg_write(6'd2, nd(1'b1, 3'd0, 8'd3));
        run(fv(8'd119, 8'd0), 3'd4, 6'd1, 1'b0);
        run(fv(8'd120, 8'd0), 3'd3, 6'd1, 1'b0);
        run(fv(8'd255, 8'd0), 3'd3, 6'd1, 1'b0);

        // out-of-range feature index reads as 0 and flags error
        cfg_write(6'd0, nd(1'b0, 3'd7, 8'd1));
        run(fv(8'd200, 8'd200), 3'd4, 6'd1, 1'b1);
        cfg_write(6'd0, nd(1'b0, 3'd4, 8'd120));
        run(fv(8'd200, 8'd0), 3'd3, 6'd1, 1'b0);

        // hold in DONE; config write there is dropped
        bus.out_ready = 1'b0;
        issue(fv(8'd10, 8'd0), 3'd4, 6'd1, 1'b0);
        wait_valid();
        repeat (3) @(negedge clk);
        cfg_write(6'd1, nd(1'b1, 3'd0, 8'd6));
        chk("busy_in_done", 32'(bus.cfg_busy), 32'd1);
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
        wait_done();
        run(fv(8'd10, 8'd0), 3'd4, 6'd1, 1'b0);

        // write and input together: write wins, input waits
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'd1;
        bus.cfg_data = nd(1'b1, 3'd0, 8'd5);
        bus.feat_in  = fv(8'd10, 8'd0);
        bus.in_valid = 1'b1;
        #1;
        chk("in_ready_vs_we", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("not_accepted", 32'(bus.cfg_busy), 32'd0);
        run(fv(8'd10, 8'd0), 3'd5, 6'd1, 1'b0);

        // full-depth chain; bottom-level node 31 forced leaf with class 5
        cfg_write(6'd0,  nd(1'b0, 3'd0, 8'd255));
        cfg_write(6'd1,  nd(1'b0, 3'd0, 8'd255));
        cfg_write(6'd3,  nd(1'b0, 3'd0, 8'd255));
        cfg_write(6'd7,  nd(1'b0, 3'd0, 8'd255));
        cfg_write(6'd15, nd(1'b0, 3'd0, 8'd255));
        cfg_write(6'd31, nd(1'b0, 3'd0, 8'd5));
        run(fv(8'd0, 8'h10), 3'd5, 6'd5, 1'b0);

        // reset mid-run at depth 2 aborts and clears the table
        @(negedge clk);
        bus.feat_in  = fv(8'd0, 8'h10);
        bus.in_valid = 1'b1;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("abort_busy", 32'(bus.cfg_busy), 32'd0);
        repeat (8) @(negedge clk);
        run(fv(8'd0, 8'h10), 3'd0, 6'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
